digit_serial_adder: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor for the arithmetic benchmark set. It captures two WIDTH-bit operands, processes DIGIT bits per clock with a registered carry between digits, and returns sum, carry-out and signed overflow. Operands enter and results leave through valid/ready handshakes. It is the sequential, width-generic counterpart of the fixed 8-bit combinational XOR/AND adder, trading area for latency.

---
 rtl/digit_serial_adder.sv | 146 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, 1-bit
// carry register between digits, valid/ready handshakes on operands and result.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  generate
    if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  int               base_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT:0]   dig_s;
  logic             last_s;

  // Next-state logic for the IDLE -> RUN -> DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Digit slice selection and the DIGIT-bit adder with carry in/out.
  always_comb begin
    base_s  = 32'(k_r) * DIGIT;
    a_dig_s = a_r[base_s +: DIGIT];
    b_dig_s = b_r[base_s +: DIGIT];
    dig_s   = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, c_r};
    last_s  = (k_r == K_LAST);
  end

  // Operand capture, per-digit accumulation and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= 1'b0;
      k_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1; the +1 rides in on the carry register.
            a_r    <= a;
            b_r    <= b ^ {WIDTH{sub}};
            c_r    <= cin ^ sub;
            k_r    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
          end
        end
        RUN: begin
          sum_r[base_s +: DIGIT] <= dig_s[DIGIT-1:0];
          c_r                    <= dig_s[DIGIT];
          if (last_s) begin
            cout_r <= dig_s[DIGIT];
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (dig_s[DIGIT-1] != a_r[WIDTH-1]);
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        DONE: begin
          cout_r <= cout_r;
        end
        default: begin
          k_r <= '0;
        end
      endcase
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed table + corner sequences for the digit-serial adder, with a lockstep
// parameter sweep (8/2, 8/1, 8/4, 8/8, 16/4) checked against a reference model.
module tb_digit_serial_adder;

  localparam int ND = 5;
  localparam int NV [ND] = '{4, 8, 2, 1, 4};
  localparam int WV [ND] = '{8, 8, 8, 8, 16};

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, sub, cin;
  logic [15:0] a16, b16;
  logic [ND-1:0] ir, ov, co, of;
  logic [7:0]  s0, s1, s2, s3;
  logic [15:0] s4;
  logic [15:0] so [ND];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       sub, cin;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a16[7:0]), .b(b16[7:0]), .sub(sub), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(s0), .cout(co[0]), .ovf(of[0]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a16[7:0]), .b(b16[7:0]), .sub(sub), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(s1), .cout(co[1]), .ovf(of[1]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a16[7:0]), .b(b16[7:0]), .sub(sub), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(s2), .cout(co[2]), .ovf(of[2]));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .a(a16[7:0]), .b(b16[7:0]), .sub(sub), .cin(cin), .out_valid(ov[3]), .out_ready(out_ready),
    .sum(s3), .cout(co[3]), .ovf(of[3]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]),
    .a(a16), .b(b16), .sub(sub), .cin(cin), .out_valid(ov[4]), .out_ready(out_ready),
    .sum(s4), .cout(co[4]), .ovf(of[4]));

  always_comb begin
    so[0] = {8'h00, s0};
    so[1] = {8'h00, s1};
    so[2] = {8'h00, s2};
    so[3] = {8'h00, s3};
    so[4] = s4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} of a +/- b +/- cin for width w.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] va, input logic [15:0] vb,
                                         input logic vs, input logic vc);
    logic [16:0] mask, ae, be, full, sm;
    logic        c_o, o_v;
    mask = (17'd1 << w) - 17'd1;
    ae   = {1'b0, va} & mask;
    be   = (vs ? ~{1'b0, vb} : {1'b0, vb}) & mask;
    full = ae + be + {16'd0, vc ^ vs};
    sm   = full & mask;
    c_o  = full[w];
    o_v  = (ae[w-1] == be[w-1]) && (sm[w-1] != ae[w-1]);
    return {o_v, c_o, sm[15:0]};
  endfunction

  // One operation on all instances in lockstep; checks latency and results of each.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vs, input logic vc,
                        output logic [17:0] main_res);
    logic [17:0] res [ND];
    int          lat [ND];
    @(negedge clk);
    chk("in_ready_all_before_accept", {27'd0, ir}, 32'h1F);
    a16 = va; b16 = vb; sub = vs; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < ND; i++) begin
      lat[i] = 0;
      res[i] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a16 = ~va; b16 = va ^ vb; sub = ~vs; cin = ~vc;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < ND; i++) begin
        if (lat[i] == 0 && ov[i]) begin
          lat[i] = j;
          res[i] = {of[i], co[i], so[i]};
        end
      end
    end
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("latency_w%0d_n%0d", WV[i], NV[i]), 32'(lat[i]), 32'(NV[i]));
      chk($sformatf("result_w%0d_n%0d", WV[i], NV[i]), {14'd0, res[i]}, {14'd0, ref_op(WV[i], va, vb, vs, vc)});
    end
    main_res = res[0];
  endtask

  initial begin
    logic [17:0] r;
    int          lat0;
    logic        ready_seen, hold_bad, ov_seen;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[7] = '{8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1};
    tbl[8] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[9] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    a16 = 16'h0000; b16 = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {27'd0, ir}, 32'h1F);
    chk("reset_out_valid", {27'd0, ov}, 32'h0);
    chk("reset_outputs", {22'd0, s0, co[0], of[0]}, 32'h0);
    rst = 1'b0;

    // Directed table on the 8/2 instance
    for (int t = 0; t < 10; t++) begin
      run_op({8'h00, tbl[t].a}, {8'h00, tbl[t].b}, tbl[t].sub, tbl[t].cin, r);
      chk($sformatf("table%0d_sum", t), {24'd0, r[7:0]}, {24'd0, tbl[t].s});
      chk($sformatf("table%0d_cout", t), {31'd0, r[16]}, {31'd0, tbl[t].co});
      chk($sformatf("table%0d_ovf", t), {31'd0, r[17]}, {31'd0, tbl[t].ov});
    end

    // Back-pressure: result held, extra requests ignored
    @(negedge clk);
    a16 = 16'h0012; b16 = 16'h0034; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat0 = 0; ready_seen = 1'b0; hold_bad = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      in_valid = (j % 2 == 1);
      a16 = 16'(j * 37); b16 = 16'(j * 91); sub = (j % 3 == 0);
      @(posedge clk);
      #1;
      if (ir[0]) ready_seen = 1'b1;
      if (lat0 == 0 && ov[0]) lat0 = j;
      if (lat0 != 0 && (!ov[0] || s0 != 8'h46 || co[0] || of[0])) hold_bad = 1'b1;
    end
    chk("bp_latency", 32'(lat0), 32'd4);
    chk("bp_in_ready_low", {31'd0, ready_seen}, 32'd0);
    chk("bp_outputs_held", {31'd0, hold_bad}, 32'd0);
    chk("bp_sum", {24'd0, s0}, 32'h46);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {27'd0, ov}, 32'h0);
    chk("bp_release_in_ready", {27'd0, ir}, 32'h1F);

    // Reset in the middle of RUN (edge that would process k=2)
    @(negedge clk);
    a16 = 16'h003C; b16 = 16'h0055; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {27'd0, ir}, 32'h1F);
    chk("midrst_out_valid", {27'd0, ov}, 32'h0);
    chk("midrst_outputs", {22'd0, s0, co[0], of[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (ov != '0) ov_seen = 1'b1;
    end
    chk("midrst_no_out_valid", {31'd0, ov_seen}, 32'd0);
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, r);
    chk("after_rst_sum", {14'd0, r}, 32'h00030);

    // Random sweep across all parameter sets
    for (int n = 0; n < 1000; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
